spi_ram_burst: RTL and testbench

Parametrised successor of the SPI-slave single-port sync RAM. It decodes the same 2-bit command prefix on a (DATA_W+2)-bit word from the SPI slave. Changes from the previous RAM:
- separate write and read address pointers, with optional auto-increment for burst transfers;
- a one-entry read-response holding register with tx_ready backpressure;
- sticky error flags for out-of-range addresses and dropped reads.

---
 rtl/spi_ram_burst_if.sv | 14 +
 rtl/spi_ram_burst.sv | 95 +++++++++
 tb/tb_spi_ram_burst.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_burst_if.sv
// Command/response bus between the SPI slave front end and spi_ram_burst.
// master = SPI slave side (issues commands, consumes read data); slave = RAM side.
interface spi_ram_burst_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W+1:0] din;
    logic              rx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;

    modport master (output din, rx_valid, tx_ready, input dout, tx_valid);
    modport slave  (input din, rx_valid, tx_ready, output dout, tx_valid);
endinterface

// File: rtl/spi_ram_burst.sv
// Command-decoded sync RAM behind an SPI slave: independent write/read pointers with
// optional burst auto-increment, a one-entry read-response register and sticky error flags.
module spi_ram_burst #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter bit AUTO_INC  = 1'b1
) (
    input  logic           clk,
    input  logic           arst_n,
    spi_ram_burst_if.slave bus,
    input  logic           err_clr,
    output logic           addr_err,
    output logic           rd_ovf
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] addr_payload;
    logic [1:0]        cmd;
    logic [DATA_W-1:0] payload;
    logic              addr_ok;
    logic              rd_accept;
    logic              tx_done;
    logic [DATA_W-1:0] dout_q;
    logic              tx_valid_q;

    assign cmd          = bus.din[DATA_W+1:DATA_W];
    assign payload      = bus.din[DATA_W-1:0];
    assign addr_payload = ADDR_W'(payload);
    assign addr_ok      = {1'b0, addr_payload} < DEPTH_EXT;
    assign tx_done      = tx_valid_q && bus.tx_ready;
    assign rd_accept    = !tx_valid_q || bus.tx_ready;

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;

    // Wrap at MEM_DEPTH-1 explicitly so non-power-of-two depths behave correctly.
    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + ADDR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (arst_n && bus.rx_valid && cmd == 2'b01)
            mem[wr_ptr] <= payload;
    end

    // Flag clears are written before the sets so a coincident error wins.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            addr_err   <= 1'b0;
            rd_ovf     <= 1'b0;
        end else begin
            if (err_clr) begin
                addr_err <= 1'b0;
                rd_ovf   <= 1'b0;
            end
            if (tx_done)
                tx_valid_q <= 1'b0;
            if (bus.rx_valid) begin
                case (cmd)
                    2'b00: begin
                        if (addr_ok) wr_ptr   <= addr_payload;
                        else         addr_err <= 1'b1;
                    end
                    2'b01: begin
                        if (AUTO_INC) wr_ptr <= next_ptr(wr_ptr);
                    end
                    2'b10: begin
                        if (addr_ok) rd_ptr   <= addr_payload;
                        else         addr_err <= 1'b1;
                    end
                    default: begin
                        if (rd_accept) begin
                            dout_q     <= mem[rd_ptr];
                            tx_valid_q <= 1'b1;
                            if (AUTO_INC) rd_ptr <= next_ptr(rd_ptr);
                        end else begin
                            rd_ovf <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Drives two spi_ram_burst instances (depth 200 with auto-increment, depth 12 / 4-bit
// pointers static) with identical directed and random commands against an array model.
module tb_spi_ram_burst;

    logic clk;
    logic arst_n;
    logic err_clr;
    logic addr_err_a, rd_ovf_a, addr_err_b, rd_ovf_b;

    spi_ram_burst_if #(.DATA_W(8)) bus_a ();
    spi_ram_burst_if #(.DATA_W(8)) bus_b ();

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1'b1)) dut_a (
        .clk(clk), .arst_n(arst_n), .bus(bus_a),
        .err_clr(err_clr), .addr_err(addr_err_a), .rd_ovf(rd_ovf_a)
    );

    spi_ram_burst #(.DATA_W(8), .ADDR_W(4), .MEM_DEPTH(12), .AUTO_INC(1'b0)) dut_b (
        .clk(clk), .arst_n(arst_n), .bus(bus_b),
        .err_clr(err_clr), .addr_err(addr_err_b), .rd_ovf(rd_ovf_b)
    );

    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;

    int m_depth [2] = '{200, 12};
    int m_abits [2] = '{8, 4};
    bit m_ainc  [2] = '{1'b1, 1'b0};

    int         m_wr     [2];
    int         m_rd     [2];
    logic [7:0] m_dout   [2];
    bit         m_dknown [2];
    bit         m_txv    [2];
    bit         m_aerr   [2];
    bit         m_ovf    [2];
    logic [7:0] m_mem    [2][256];
    bit         m_wrote  [2][256];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural next-state of one RAM instance, computed from the command rules.
    task automatic modelStep(input int k, input bit rst_n, input logic [1:0] cmd,
                             input logic [7:0] pl, input bit rxv, input bit txr, input bit eclr);
        int addr;
        if (!rst_n) begin
            m_wr[k] = 0; m_rd[k] = 0; m_dout[k] = 8'h00; m_dknown[k] = 1'b1;
            m_txv[k] = 1'b0; m_aerr[k] = 1'b0; m_ovf[k] = 1'b0;
            return;
        end
        addr = int'(pl) % (1 << m_abits[k]);
        if (eclr) begin
            m_aerr[k] = 1'b0;
            m_ovf[k]  = 1'b0;
        end
        if (m_txv[k] && txr) begin
            m_txv[k] = 1'b0;
            if (rxv && cmd == 2'b11) m_txv[k] = 1'b0;
        end
        if (!rxv) return;
        case (cmd)
            2'b00: if (addr < m_depth[k]) m_wr[k] = addr; else m_aerr[k] = 1'b1;
            2'b01: begin
                m_mem[k][m_wr[k]]   = pl;
                m_wrote[k][m_wr[k]] = 1'b1;
                if (m_ainc[k]) m_wr[k] = (m_wr[k] + 1) % m_depth[k];
            end
            2'b10: if (addr < m_depth[k]) m_rd[k] = addr; else m_aerr[k] = 1'b1;
            default: begin
                // The register was freed above if a transfer happened this edge.
                if (!m_txv[k]) begin
                    m_dout[k]   = m_mem[k][m_rd[k]];
                    m_dknown[k] = m_wrote[k][m_rd[k]];
                    m_txv[k]    = 1'b1;
                    if (m_ainc[k]) m_rd[k] = (m_rd[k] + 1) % m_depth[k];
                end else begin
                    m_ovf[k] = 1'b1;
                end
            end
        endcase
    endtask

    task automatic compareDut(input int k, input string nm, input logic txv, input logic [7:0] dout,
                              input logic aerr, input logic ovf, input logic [7:0] wr, input logic [7:0] rd);
        checkOutput({nm, "_tx_valid"}, 32'(txv), 32'(m_txv[k]));
        if (m_dknown[k]) checkOutput({nm, "_dout"}, 32'(dout), 32'(m_dout[k]));
        checkOutput({nm, "_addr_err"}, 32'(aerr), 32'(m_aerr[k]));
        checkOutput({nm, "_rd_ovf"}, 32'(ovf), 32'(m_ovf[k]));
        checkOutput({nm, "_wr_ptr"}, 32'(wr), 32'(m_wr[k]));
        checkOutput({nm, "_rd_ptr"}, 32'(rd), 32'(m_rd[k]));
    endtask

    task automatic applyStimulus(input bit rst_n, input logic [1:0] cmd, input logic [7:0] pl,
                                 input bit rxv, input bit txr, input bit eclr);
        @(negedge clk);
        arst_n         = rst_n;
        bus_a.din      = {cmd, pl};
        bus_b.din      = {cmd, pl};
        bus_a.rx_valid = rxv;
        bus_b.rx_valid = rxv;
        bus_a.tx_ready = txr;
        bus_b.tx_ready = txr;
        err_clr        = eclr;
        for (int k = 0; k < 2; k++) modelStep(k, rst_n, cmd, pl, rxv, txr, eclr);
        @(posedge clk);
        #1;
        compareDut(0, "A", bus_a.tx_valid, bus_a.dout, addr_err_a, rd_ovf_a, dut_a.wr_ptr, dut_a.rd_ptr);
        compareDut(1, "B", bus_b.tx_valid, bus_b.dout, addr_err_b, rd_ovf_b, 8'(dut_b.wr_ptr), 8'(dut_b.rd_ptr));
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        clk = 1'b0; arst_n = 1'b0; err_clr = 1'b0;
        bus_a.din = '0; bus_a.rx_valid = 1'b0; bus_a.tx_ready = 1'b0;
        bus_b.din = '0; bus_b.rx_valid = 1'b0; bus_b.tx_ready = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 256; a++) m_wrote[k][a] = 1'b0;

        // Single write then read of the same address.
        applyStimulus(0, 2'b00, 8'h00, 0, 0, 0);
        applyStimulus(1, 2'b00, 8'h10, 1, 1, 0);
        applyStimulus(1, 2'b01, 8'hA5, 1, 1, 0);
        applyStimulus(1, 2'b10, 8'h10, 1, 1, 0);
        applyStimulus(1, 2'b11, 8'h00, 1, 1, 0);
        checkOutput("t1_dout", 32'(bus_a.dout), 32'hA5);
        checkOutput("t1_txv", 32'(bus_a.tx_valid), 32'h1);
        checkOutput("t1_wr_ptr", 32'(dut_a.wr_ptr), 32'h11);
        applyStimulus(1, 2'b00, 8'h00, 0, 1, 0);
        checkOutput("t1_txv_drop", 32'(bus_a.tx_valid), 32'h0);

        // Burst across the depth-200 wrap point (198, 199, 0).
        applyStimulus(1, 2'b00, 8'hC6, 1, 1, 0);
        applyStimulus(1, 2'b01, 8'h11, 1, 1, 0);
        applyStimulus(1, 2'b01, 8'h22, 1, 1, 0);
        applyStimulus(1, 2'b01, 8'h33, 1, 1, 0);
        applyStimulus(1, 2'b10, 8'hC6, 1, 1, 0);
        applyStimulus(1, 2'b11, 8'h00, 1, 1, 0);
        checkOutput("t2_dout0", 32'(bus_a.dout), 32'h11);
        applyStimulus(1, 2'b11, 8'h00, 1, 1, 0);
        checkOutput("t2_dout1", 32'(bus_a.dout), 32'h22);
        applyStimulus(1, 2'b11, 8'h00, 1, 1, 0);
        checkOutput("t2_dout2", 32'(bus_a.dout), 32'h33);
        checkOutput("t2_rd_ptr", 32'(dut_a.rd_ptr), 32'h01);
        checkOutput("t2_b_dout", 32'(bus_b.dout), 32'h33);

        // Backpressure: second read dropped, then transfer and reload on the same edge.
        applyStimulus(1, 2'b00, 8'h11, 1, 1, 0);
        applyStimulus(1, 2'b01, 8'h5A, 1, 1, 0);
        applyStimulus(1, 2'b10, 8'h10, 1, 1, 0);
        applyStimulus(1, 2'b11, 8'h00, 1, 0, 0);
        applyStimulus(1, 2'b11, 8'h00, 1, 0, 0);
        checkOutput("t3_hold_dout", 32'(bus_a.dout), 32'hA5);
        checkOutput("t3_rd_ovf", 32'(rd_ovf_a), 32'h1);
        checkOutput("t3_rd_ptr", 32'(dut_a.rd_ptr), 32'h11);
        applyStimulus(1, 2'b11, 8'h00, 1, 1, 0);
        checkOutput("t3_reload", 32'(bus_a.dout), 32'h5A);
        checkOutput("t3_txv", 32'(bus_a.tx_valid), 32'h1);

        // Out-of-range address and err_clr precedence.
        applyStimulus(1, 2'b00, 8'hC8, 1, 1, 0);
        checkOutput("t4_addr_err", 32'(addr_err_a), 32'h1);
        checkOutput("t4_wr_ptr", 32'(dut_a.wr_ptr), 32'h12);
        applyStimulus(1, 2'b01, 8'h77, 1, 1, 0);
        applyStimulus(1, 2'b00, 8'h00, 0, 1, 1);
        checkOutput("t4_clr", 32'(addr_err_a), 32'h0);
        applyStimulus(1, 2'b00, 8'hFF, 1, 1, 1);
        checkOutput("t4_set_wins", 32'(addr_err_a), 32'h1);

        // Reset with a pending response; memory survives.
        applyStimulus(1, 2'b10, 8'h12, 1, 1, 0);
        applyStimulus(1, 2'b11, 8'h00, 1, 0, 0);
        applyStimulus(0, 2'b01, 8'hEE, 1, 0, 0);
        checkOutput("t5_dout", 32'(bus_a.dout), 32'h0);
        checkOutput("t5_txv", 32'(bus_a.tx_valid), 32'h0);
        checkOutput("t5_flag", 32'(addr_err_a), 32'h0);
        applyStimulus(1, 2'b10, 8'h12, 1, 1, 0);
        applyStimulus(1, 2'b11, 8'h00, 1, 1, 0);
        checkOutput("t5_mem_kept", 32'(bus_a.dout), 32'h77);

        // Static pointers overwrite one location; idle cycles ignore garbage din.
        applyStimulus(1, 2'b00, 8'h03, 1, 1, 0);
        applyStimulus(1, 2'b01, 8'h44, 1, 1, 0);
        applyStimulus(1, 2'b01, 8'h99, 1, 1, 0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 2'(i), 8'($urandom), 0, 1, 0);
        applyStimulus(1, 2'b10, 8'h03, 1, 1, 0);
        applyStimulus(1, 2'b11, 8'h00, 1, 1, 0);
        checkOutput("t6_b_overwrite", 32'(bus_b.dout), 32'h99);
        checkOutput("t6_a_first", 32'(bus_a.dout), 32'h44);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 2000; i++) begin
            logic [1:0] c;
            logic [7:0] p;
            c = 2'($urandom_range(0, 3));
            p = (c[0] == 1'b0) ? 8'($urandom_range(0, 215)) : 8'($urandom);
            applyStimulus(($urandom_range(0, 99) != 0), c, p,
                          ($urandom_range(0, 9) < 8), ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
